// File: rtl/bus_arbiter_2to1_if.sv
// Bus bundle for the internal 32-bit register/memory bus.
// One instance carries a single point-to-point link: command from the
// initiator, response and stall from the target.
interface bus_arbiter_2to1_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   addr;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   readdata;
    logic [1:0]              response;
    logic                    waitrequest;

    // Initiator end of the link: drives the command, receives data/response/stall.
    modport master (
        output addr,
        output read,
        output write,
        output writedata,
        output byteenable,
        input  readdata,
        input  response,
        input  waitrequest
    );

    // Target end of the link: receives the command, drives data/response/stall.
    modport slave (
        input  addr,
        input  read,
        input  write,
        input  writedata,
        input  byteenable,
        output readdata,
        output response,
        output waitrequest
    );

endinterface

// File: rtl/bus_arbiter_2to1.sv
// Two-initiator to one-target arbiter for the internal register/memory bus.
// Round-robin arbitration; the grant is held until the transfer completes.
// A watchdog abandons transfers the target never acknowledges and returns
// SLVERR to the granted initiator. One idle cycle separates transfers.
module bus_arbiter_2to1 #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    bus_arbiter_2to1_if.slave  s0_bus,
    bus_arbiter_2to1_if.slave  s1_bus,
    bus_arbiter_2to1_if.master m0_bus
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;

    // Watchdog counter: at least 8 bits, wide enough to hold TIMEOUT_CYCLES.
    localparam int WD_NEED   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WD_BITS   = (WD_NEED < 8) ? 8 : WD_NEED;
    localparam bit WD_ENABLE = (TIMEOUT_CYCLES != 0);
    localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(TIMEOUT_CYCLES);
    localparam logic [WD_BITS-1:0] WD_MAX   = '1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    state_t             state_out;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [WD_BITS-1:0] wd_count_q, wd_count_d;

    // ------------------------------------------------------------------
    // Request decode and granted-initiator command mux
    // ------------------------------------------------------------------
    logic                  req0, req1;
    logic                  arb_winner;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic                  g_read;
    logic                  g_write;
    logic [DATA_WIDTH-1:0] g_writedata;
    logic [BE_WIDTH-1:0]   g_byteenable;
    logic                  g_req;

    // Watchdog helpers
    logic [WD_BITS-1:0] wd_inc;
    logic               wd_expire;

    // Per-initiator response path, index = initiator number
    logic                  s_wait  [2];
    logic [DATA_WIDTH-1:0] s_rdata [2];
    logic [1:0]            s_resp  [2];

    // Target command
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic                  m0_read;
    logic                  m0_write;
    logic [DATA_WIDTH-1:0] m0_writedata;
    logic [BE_WIDTH-1:0]   m0_byteenable;

    // Round-robin pick: on a tie the initiator not granted last wins.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
            return ~last;
        end
        return r1;
    endfunction

    assign req0       = s0_bus.read | s0_bus.write;
    assign req1       = s1_bus.read | s1_bus.write;
    assign arb_winner = pick_winner(req0, req1, last_grant_q);

    assign g_addr       = grant_q ? s1_bus.addr       : s0_bus.addr;
    assign g_read       = grant_q ? s1_bus.read       : s0_bus.read;
    assign g_write      = grant_q ? s1_bus.write      : s0_bus.write;
    assign g_writedata  = grant_q ? s1_bus.writedata  : s0_bus.writedata;
    assign g_byteenable = grant_q ? s1_bus.byteenable : s0_bus.byteenable;
    assign g_req        = g_read | g_write;

    // The count includes the current stalled cycle and saturates rather than wraps,
    // so the transfer is cut after exactly TIMEOUT_CYCLES stalled cycles.
    assign wd_inc    = (wd_count_q == WD_MAX) ? wd_count_q : wd_count_q + WD_BITS'(1);
    assign wd_expire = WD_ENABLE && m0_bus.waitrequest && (wd_inc == WD_LIMIT);

    // ------------------------------------------------------------------
    // State register with synchronous reset
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wd_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wd_count_q   <= wd_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, grant and watchdog logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a hold/idle default before the case, so no
    // path through the block can infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wd_count_d   = wd_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_d    = arb_winner;
                    wd_count_d = '0;
                    state_d    = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (!g_req) begin
                    // Initiator withdrew mid-transfer: abandon silently, keep
                    // the round-robin pointer where it was.
                    state_d = ST_IDLE;
                end else if (!m0_bus.waitrequest) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end else begin
                    wd_count_d = wd_inc;
                    if (wd_expire) begin
                        state_d = ST_ERR;
                    end
                end
            end

            ST_ERR: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: reset is synchronous and only acts at the next edge, so the output
    // decode also treats rst=1 as IDLE to drop the m0 command in the same cycle.
    assign state_out = rst ? ST_IDLE : state_q;

    // ------------------------------------------------------------------
    // Command forwarding and response steering from the reset-gated state
    // ------------------------------------------------------------------
    always_comb begin
        m0_addr       = '0;
        m0_read       = 1'b0;
        m0_write      = 1'b0;
        m0_writedata  = '0;
        m0_byteenable = '0;
        for (int i = 0; i < 2; i++) begin
            s_wait[i]  = 1'b1;
            s_rdata[i] = '0;
            s_resp[i]  = RESP_OKAY;
        end

        unique case (state_out)
            ST_BUSY: begin
                m0_addr          = g_addr;
                m0_read          = g_read;
                m0_write         = g_write;
                m0_writedata     = g_writedata;
                m0_byteenable    = g_byteenable;
                s_wait[grant_q]  = m0_bus.waitrequest;
                s_rdata[grant_q] = m0_bus.readdata;
                s_resp[grant_q]  = m0_bus.response;
            end

            ST_ERR: begin
                // Target transfer is abandoned; the initiator gets SLVERR for one cycle.
                s_wait[grant_q] = 1'b0;
                s_resp[grant_q] = RESP_SLVERR;
            end

            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Port hookup
    // ------------------------------------------------------------------
    assign m0_bus.addr       = m0_addr;
    assign m0_bus.read       = m0_read;
    assign m0_bus.write      = m0_write;
    assign m0_bus.writedata  = m0_writedata;
    assign m0_bus.byteenable = m0_byteenable;

    assign s0_bus.waitrequest = s_wait[0];
    assign s0_bus.readdata    = s_rdata[0];
    assign s0_bus.response    = s_resp[0];

    assign s1_bus.waitrequest = s_wait[1];
    assign s1_bus.readdata    = s_rdata[1];
    assign s1_bus.response    = s_resp[1];

endmodule

// File: doc/bus_arbiter_2to1.md
Name: bus_arbiter_2to1

Overview:
- Two-initiator to one-target arbiter for the internal 32-bit register/memory bus. This is the many-to-one counterpart of the one-to-many address-decode interconnect.
- Lets two bus initiators share one downstream port, for example the host control bridge and the DSI command engine sharing the decode interconnect's slave port.
- Uses round-robin arbitration and holds the grant until the current transfer completes.
- A watchdog terminates transfers the target never acknowledges, returning an error response.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, data width on all ports; byteenable width is DATA_WIDTH/8
TIMEOUT_CYCLES, 255, max cycles a granted transfer may see m0_bus_waitrequest=1; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
s0_bus_addr  in  ADDR_WIDTH  initiator 0 address
s0_bus_read  in  1  initiator 0 read request
s0_bus_write  in  1  initiator 0 write request
s0_bus_writedata  in  DATA_WIDTH  initiator 0 write data
s0_bus_byteenable  in  DATA_WIDTH/8  initiator 0 byte enables
s0_bus_readdata  out  DATA_WIDTH  read data to initiator 0
s0_bus_response  out  2  00 OKAY, 10 SLVERR, 11 DECODEERR
s0_bus_waitrequest  out  1  stall to initiator 0
s1_bus_*  (same eight signals, same directions and widths)  initiator 1
m0_bus_addr  out  ADDR_WIDTH  target address
m0_bus_read  out  1  target read
m0_bus_write  out  1  target write
m0_bus_writedata  out  DATA_WIDTH  target write data
m0_bus_byteenable  out  DATA_WIDTH/8  target byte enables
m0_bus_readdata  in  DATA_WIDTH  target read data, valid when waitrequest=0
m0_bus_response  in  2  target response
m0_bus_waitrequest  in  1  target stall

Behaviour:
Bus protocol:
- A transfer completes in the cycle where read|write=1 and waitrequest=0.
- Read data and response are valid only in that cycle.

FSM states: IDLE, BUSY, ERR.

IDLE:
- m0 read/write/addr/writedata/byteenable all 0.
- Both s*_bus_waitrequest=1; s* readdata=0 and response=00.
- If any sN requests (read|write), register the winner into grant and go to BUSY.
- Round-robin: the initiator not granted last wins a tie. last_grant resets to 1, so s0 wins the first tie.

BUSY:
- All m0 outputs mirror s[grant] combinationally.
- s[grant] sees m0 readdata, response and waitrequest directly.
- The other initiator stays at waitrequest=1, readdata=0, response=00.
- On completion (s[grant] read|write and m0 waitrequest=0): update last_grant=grant and go to IDLE.
- If s[grant] drops read|write before completion (protocol violation): go to IDLE, leave last_grant unchanged, no error reported.

Latency and throughput:
- Arbitration costs 1 cycle: a request first seen in IDLE reaches m0 on the next cycle.
- Back-to-back transfers incur 1 idle bubble, giving max throughput of 1 transfer per 2 cycles with a zero-wait target.

Watchdog:
- 8-bit minimum counter, sized clog2(TIMEOUT_CYCLES+1).
- Cleared on entry to BUSY; increments each BUSY cycle with m0 waitrequest=1.
- When count==TIMEOUT_CYCLES and waitrequest is still 1: go to ERR next cycle.
- Count saturates and never wraps.
- Disabled when TIMEOUT_CYCLES=0.

ERR (exactly 1 cycle):
- m0 read/write=0, abandoning the target transfer.
- s[grant] sees waitrequest=0, readdata=0, response=10.
- Then update last_grant and go to IDLE.

Simultaneous events:
- A new request from the non-granted initiator during BUSY or ERR is held off (waitrequest=1) and wins the next arbitration.
- Both initiators requesting continuously alternate strictly.

Reset:
- While rst=1 and on the cycle after: state=IDLE, grant=0, last_grant=1, counter=0.
- All outputs take their IDLE values: m0 read/write=0, all s*_bus_waitrequest=1.
- Reset mid-transfer drops the m0 command immediately, with no response to the initiator.
- The m0 decode is gated by state, so no command glitches out during reset.

Simultaneous read & write from one initiator: forwarded as-is; no checking.

Test Plan:
1. Single read, s0 addr 0x104, target waitrequest low, readdata 0xDEADBEEF -> m0_bus_read high 1 cycle after request; s0 sees waitrequest=0, readdata 0xDEADBEEF, response 00 the same cycle; s1 waitrequest stays 1.
2. Both initiators request writes continuously from reset for 6 transfers -> grant order s0,s1,s0,s1,s0,s1; one IDLE cycle between transfers; each m0 writedata matches the granted initiator.
3. s1 write with target waitrequest=1 for 3 cycles, s0 requests mid-transfer -> s1 completes after 3 stall cycles; s0 granted next; s0 waitrequest=1 throughout s1's transfer.
4. TIMEOUT_CYCLES=4, target holds waitrequest=1 forever on s0 read -> after 4 stalled cycles, m0_bus_read drops; s0 gets waitrequest=0, response 10, readdata 0 for 1 cycle; FSM returns to IDLE.
5. rst asserted during a stalled s1 transfer -> next cycle m0 read/write=0, both s waitrequests=1; first tie afterwards grants s0.
6. TIMEOUT_CYCLES=0, target stalls 1000 cycles then responds with response 11 -> no timeout; s0 receives response 11 on completion.
